// File: rtl/fft_pkg.sv
// Shared types and constants for the 64-point radix-2 DIT FFT address/twiddle sequencer.
package fft_pkg;

    localparam int FFT_LOG2N  = 6;
    localparam int FFT_N      = 64;
    localparam int TW_QUARTER = 16;

    typedef logic [FFT_LOG2N-1:0] fft_addr_t;
    typedef logic [2:0]           fft_stage_t;
    typedef logic [FFT_LOG2N-2:0] fft_bf_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly descriptor: (stage, butterfly index, inverse) -> data addresses and twiddle ROM selects.
module fft_bf_addr_gen
    import fft_pkg::*;
(
    input  fft_stage_t stage_i,
    input  fft_bf_t    b_i,
    input  logic       inverse_i,
    output fft_addr_t  addr_a_o,
    output fft_addr_t  addr_b_o,
    output fft_addr_t  tw_re_sel_o,
    output fft_addr_t  tw_im_sel_o
);

    fft_addr_t half;
    fft_addr_t bx;
    fft_addr_t pos;
    fft_addr_t grp;
    fft_addr_t base;
    fft_addr_t k;

    always_comb begin
        half = fft_addr_t'(1) << stage_i;
        bx   = {1'b0, b_i};
        pos  = bx & (half - fft_addr_t'(1));
        grp  = bx >> stage_i;
        // grp * 2 * half is a left shift by stage+1; pos < half so OR equals add
        base = (grp << (stage_i + 3'd1)) | pos;
        k    = pos << (3'd5 - stage_i);

        addr_a_o    = base;
        addr_b_o    = base + half;
        // cos(x) = -sin(x - pi/2): three quarters further round the -sin table
        tw_re_sel_o = k + fft_addr_t'(3 * TW_QUARTER);
        tw_im_sel_o = inverse_i ? fft_addr_t'(FFT_N - int'(k)) : k;
    end

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Stage/butterfly sequencer for the in-place 64-point FFT with inter-stage pipeline drain.
// Optional inverse-transform twiddle conjugation is enabled by defining FFT_INVERSE_EN.
module fft_twiddle_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N      = 6,
    parameter int BF_LATENCY = 3
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FFT_INVERSE_EN
    input  logic             inverse,
`endif
    output logic             busy,
    output logic             done,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-1:0] tw_re_sel,
    output logic [LOG2N-1:0] tw_im_sel,
    output logic [2:0]       stage,
    output logic             last_in_stage
);

    localparam int               CNT_W      = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(BF_LATENCY - 1);
    localparam fft_bf_t          BF_LAST    = '1;
    localparam fft_stage_t       STAGE_LAST = 3'd5;

    seq_state_e       state_q, state_d;
    fft_stage_t       stage_q, stage_d;
    fft_bf_t          b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inv_d;
`ifdef FFT_INVERSE_EN
    logic             inv_q;
`endif

    fft_addr_t        gen_a, gen_b, gen_re, gen_im;

    logic             valid_q, busy_q, done_q, last_q;
    logic [LOG2N-1:0] addr_a_q, addr_b_q, tw_re_q, tw_im_q;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
`ifdef FFT_INVERSE_EN
        inv_d   = inv_q;
`else
        inv_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    b_d     = '0;
`ifdef FFT_INVERSE_EN
                    inv_d   = inverse;
`endif
                end
            end
            RUN: begin
                // bf_valid is always high in RUN, so bf_ready alone completes the handshake
                if (bf_ready) begin
                    if (b_q == BF_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        b_d = b_q + fft_bf_t'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + fft_stage_t'(1);
                        b_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Descriptor is computed from the next-state counters so the outputs can be registered.
    fft_bf_addr_gen u_addr_gen (
        .stage_i     (stage_d),
        .b_i         (b_d),
        .inverse_i   (inv_d),
        .addr_a_o    (gen_a),
        .addr_b_o    (gen_b),
        .tw_re_sel_o (gen_re),
        .tw_im_sel_o (gen_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
`ifdef FFT_INVERSE_EN
            inv_q    <= 1'b0;
`endif
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_re_q  <= '0;
            tw_im_q  <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
`ifdef FFT_INVERSE_EN
            inv_q    <= inv_d;
`endif
            valid_q  <= (state_d == RUN);
            busy_q   <= (state_d == RUN) || (state_d == DRAIN);
            done_q   <= (state_d == DONE);
            last_q   <= (state_d == RUN) && (b_d == BF_LAST);
            // Held during DRAIN/DONE, cleared in IDLE; a stalled RUN reloads identical values
            if (state_d == RUN) begin
                addr_a_q <= gen_a;
                addr_b_q <= gen_b;
                tw_re_q  <= gen_re;
                tw_im_q  <= gen_im;
            end else if (state_d == IDLE) begin
                addr_a_q <= '0;
                addr_b_q <= '0;
                tw_re_q  <= '0;
                tw_im_q  <= '0;
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bf_valid      = valid_q;
    assign addr_a        = addr_a_q;
    assign addr_b        = addr_b_q;
    assign tw_re_sel     = tw_re_q;
    assign tw_im_sel     = tw_im_q;
    assign stage         = stage_q;
    assign last_in_stage = last_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed self-checking bench for fft_twiddle_sequencer and its descriptor generator.
module tb_fft_twiddle_sequencer;
    import fft_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       bf_ready;
    logic       busy, done, bf_valid, last_in_stage;
    logic [5:0] addr_a, addr_b, tw_re_sel, tw_im_sel;
    logic [2:0] stage;
`ifdef FFT_INVERSE_EN
    logic       inverse = 1'b0;
`endif

    fft_stage_t g_stage;
    fft_bf_t    g_b;
    logic       g_inv;
    fft_addr_t  g_a, g_bb, g_re, g_im;

    int checks   = 0;
    int failures = 0;

    logic [23:0] d_s2b5, d_s5b31;
    logic        l_s2b5, l_s5b31;

    always #5 clk = ~clk;

    fft_twiddle_sequencer #(.LOG2N(6), .BF_LATENCY(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
`ifdef FFT_INVERSE_EN
        .inverse       (inverse),
`endif
        .busy          (busy),
        .done          (done),
        .bf_valid      (bf_valid),
        .bf_ready      (bf_ready),
        .addr_a        (addr_a),
        .addr_b        (addr_b),
        .tw_re_sel     (tw_re_sel),
        .tw_im_sel     (tw_im_sel),
        .stage         (stage),
        .last_in_stage (last_in_stage)
    );

    fft_bf_addr_gen u_gen (
        .stage_i     (g_stage),
        .b_i         (g_b),
        .inverse_i   (g_inv),
        .addr_a_o    (g_a),
        .addr_b_o    (g_bb),
        .tw_re_sel_o (g_re),
        .tw_im_sel_o (g_im)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent arithmetic model of the descriptor: {addr_a, addr_b, re_sel, im_sel}
    function automatic logic [23:0] model(input int s, input int b);
        int half, pos, grp, a, k;
        half = 1 << s;
        pos  = b % half;
        grp  = b / half;
        a    = grp * 2 * half + pos;
        k    = pos * (32 / half);
        return {6'(a), 6'(a + half), 6'((k + 48) % 64), 6'(k)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues start and follows one transform to its done pulse.
    task automatic run_transform(input bit rnd, input bit spurious,
                                 output int hs, output int done_cyc, output int stalls);
        int          cyc, desc_err, stab_err, gap, ngaps, gap_err, s, b;
        bit          got_done, pv, pr;
        logic [26:0] prev, cur;
        hs = 0; done_cyc = 0; stalls = 0;
        desc_err = 0; stab_err = 0; gap = 0; ngaps = 0; gap_err = 0;
        got_done = 0; pv = 0; pr = 0; prev = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("first_valid", {busy, bf_valid}, 2'b11);
        check("first_desc", {addr_a, addr_b, tw_re_sel, tw_im_sel}, {6'd0, 6'd1, 6'd48, 6'd0});
        for (cyc = 1; cyc < 3000 && !got_done; ) begin
            cur = {addr_a, addr_b, tw_re_sel, tw_im_sel, stage};
            if (done) begin
                done_cyc = cyc;
                got_done = 1;
            end
            if (pv && !pr && bf_valid && cur !== prev) stab_err++;
            if (busy && !bf_valid) gap++;
            else if (gap != 0) begin
                if (gap != 3) gap_err++;
                ngaps++;
                gap = 0;
            end
            bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spurious) start = got_done || cyc == 10 || cyc == 150;
            if (bf_valid && bf_ready) begin
                s = hs / 32;
                b = hs % 32;
                if ({addr_a, addr_b, tw_re_sel, tw_im_sel} !== model(s, b) ||
                    stage !== 3'(s) || last_in_stage !== (b == 31)) desc_err++;
                if (s == 2 && b == 5)  begin d_s2b5  = {addr_a, addr_b, tw_re_sel, tw_im_sel}; l_s2b5  = last_in_stage; end
                if (s == 5 && b == 31) begin d_s5b31 = {addr_a, addr_b, tw_re_sel, tw_im_sel}; l_s5b31 = last_in_stage; end
                hs++;
            end
            if (bf_valid && !bf_ready) stalls++;
            pv = bf_valid; pr = bf_ready; prev = cur;
            if (!got_done) begin
                step();
                cyc++;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("desc_sequence_errors", 32'(desc_err), 32'd0);
        check("stall_stability_errors", 32'(stab_err), 32'd0);
        check("drain_gap_count", 32'(ngaps), 32'd6);
        check("drain_gap_len_errors", 32'(gap_err), 32'd0);
    endtask

    int hs, dc, st, n, ndone;

    initial begin
        rst = 1'b1; start = 1'b0; bf_ready = 1'b0;
        g_stage = '0; g_b = '0; g_inv = 1'b0;
        step(); step();
        check("reset_outputs",
              {busy, done, bf_valid, addr_a, addr_b, tw_re_sel, tw_im_sel, stage, last_in_stage}, 32'd0);
        rst = 1'b0;
        step();

        // Descriptor generator vectors, forward and conjugated
        g_stage = 3'd2; g_b = 5'd5; g_inv = 1'b0; #1;
        check("gen_s2b5_fwd", {g_a, g_bb, g_re, g_im}, {6'd9, 6'd13, 6'd56, 6'd8});
        g_inv = 1'b1; #1;
        check("gen_s2b5_inv", {g_a, g_bb, g_re, g_im}, {6'd9, 6'd13, 6'd56, 6'd56});
        g_stage = 3'd0; g_b = 5'd3; #1;
        check("gen_s0b3_inv", {g_a, g_bb, g_re, g_im}, {6'd6, 6'd7, 6'd48, 6'd0});
        g_stage = 3'd5; g_b = 5'd31; #1;
        check("gen_s5b31_inv", {g_a, g_bb, g_re, g_im}, {6'd31, 6'd63, 6'd15, 6'd33});

        // Full transform, no backpressure
        run_transform(1'b0, 1'b0, hs, dc, st);
        check("hs_count", 32'(hs), 32'd192);
        check("done_cycle", 32'(dc), 32'd211);
        check("s2b5_desc", {8'd0, d_s2b5}, {8'd0, 6'd9, 6'd13, 6'd56, 6'd8});
        check("s2b5_last", 32'(l_s2b5), 32'd0);
        check("s5b31_desc", {8'd0, d_s5b31}, {8'd0, 6'd31, 6'd63, 6'd15, 6'd31});
        check("s5b31_last", 32'(l_s5b31), 32'd1);
        step();
        check("done_one_cycle", {busy, done, bf_valid}, 3'b000);

        // Random backpressure
        run_transform(1'b1, 1'b0, hs, dc, st);
        check("bp_hs_count", 32'(hs), 32'd192);
        check("bp_done_cycle", 32'(dc), 32'(211 + st));
        bf_ready = 1'b1;
        step();

        // Reset during stage 3
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 500 && stage != 3'd3; i++) step();
        check("reached_stage3", 32'(stage), 32'd3);
        step(); step();
        rst = 1'b1; step();
        check("midrun_reset_outputs",
              {busy, done, bf_valid, addr_a, addr_b, tw_re_sel, tw_im_sel, stage, last_in_stage}, 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) ndone++;
        end
        check("aborted_run_silent", 32'(ndone), 32'd0);
        run_transform(1'b0, 1'b0, hs, dc, st);
        check("restart_hs_count", 32'(hs), 32'd192);
        check("restart_done_cycle", 32'(dc), 32'd211);
        step();

        // Start while busy and on the done cycle is ignored
        run_transform(1'b0, 1'b1, hs, dc, st);
        check("spurious_hs_count", 32'(hs), 32'd192);
        check("spurious_done_cycle", 32'(dc), 32'd211);
        step();
        check("start_on_done_ignored", {busy, bf_valid}, 2'b00);
        step();
        start = 1'b0;
        check("fresh_start_valid", {busy, bf_valid}, 2'b11);
        check("fresh_start_desc", {stage, addr_a, addr_b, tw_re_sel, tw_im_sel},
              {3'd0, 6'd0, 6'd1, 6'd48, 6'd0});
        n = 0;
        while (!done && n < 400) begin
            step();
            n++;
        end
        check("fresh_done_cycle", 32'(n + 1), 32'd211);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
